// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select unit: state encoding,
// default constant-select settings and the drop-counter width.
package wb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } wb_state_t;

   localparam int          DEF_CONST_SEL = 7;
   localparam logic [31:0] DEF_CONST_VAL = 32'h0000_00E3;
   localparam int          DROP_W        = 4;

endpackage

// File: rtl/wb_src_decode.sv
// Combinational select decode: maps a select code to either one of the
// sources or the constant, and flags codes beyond NUM_SRC as illegal.
// Codes above CONST_SEL are shifted down by one so no source is hidden
// behind the constant slot.
module wb_src_decode
   import wb_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                NUM_SRC   = 8,
   parameter int                SEL_W     = 4,
   parameter int                CONST_SEL = DEF_CONST_SEL,
   parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(DEF_CONST_VAL)
) (
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]          sel,
   output logic                      legal,
   output logic [DATA_W-1:0]         mapped
);

   localparam logic [SEL_W-1:0] CSEL = SEL_W'(CONST_SEL);
   localparam logic [SEL_W-1:0] NSEL = SEL_W'(NUM_SRC);

   logic [SEL_W-1:0] idx;

   // Resolve select code to a source index or the constant
   always_comb begin
      legal  = (sel <= NSEL);
      mapped = '0;
      idx    = '0;
      if (sel < CSEL) begin
         idx = sel;
      end else begin
         idx = sel - 1'b1;
      end
      if (legal) begin
         if (sel == CSEL) begin
            mapped = CONST_VAL;
         end else begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
               if (idx == SEL_W'(k)) begin
                  mapped = src_data[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

endmodule

// File: rtl/wb_select_unit.sv
// Writeback select unit: captures the selected source on a request,
// holds it with a valid flag until the register file accepts it, and
// tracks illegal selects and requests dropped while busy.
module wb_select_unit
   import wb_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                NUM_SRC   = 8,
   parameter int                SEL_W     = 4,
   parameter int                CONST_SEL = DEF_CONST_SEL,
   parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(DEF_CONST_VAL)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      wb_req,
   input  logic                      wb_ready,
   output logic [DATA_W-1:0]         wb_data,
   output logic                      wb_valid,
   output logic                      busy,
   output logic                      sel_err,
   output logic [DROP_W-1:0]         drop_cnt
);

   wb_state_t           state;
   logic                dec_legal;
   logic [DATA_W-1:0]   dec_value;

   wb_src_decode #(
      .DATA_W    (DATA_W),
      .NUM_SRC   (NUM_SRC),
      .SEL_W     (SEL_W),
      .CONST_SEL (CONST_SEL),
      .CONST_VAL (CONST_VAL)
   ) u_decode (
      .src_data (src_data),
      .sel      (sel),
      .legal    (dec_legal),
      .mapped   (dec_value)
   );

   assign busy = (state == HOLD);

   // Capture/hold FSM with sticky error flag and saturating drop counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         wb_data  <= '0;
         wb_valid <= 1'b0;
         sel_err  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wb_req) begin
                  if (dec_legal) begin
                     wb_data  <= dec_value;
                     wb_valid <= 1'b1;
                     state    <= HOLD;
                  end else begin
                     sel_err  <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (wb_req && (drop_cnt != '1)) begin
                  drop_cnt <= drop_cnt + 1'b1;
               end
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               wb_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_select_unit.sv
// Self-checking bench for wb_select_unit: expected writeback values are
// queued when a capture is requested and matched against the values the
// monitor sees accepted by the register file.
module tb_wb_select_unit;

   localparam int DATA_W = 32;
   localparam int NUM_SRC = 8;
   localparam int SEL_W = 4;

   logic                      clk;
   logic                      reset;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [SEL_W-1:0]          sel;
   logic                      wb_req;
   logic                      wb_ready;
   logic [DATA_W-1:0]         wb_data;
   logic                      wb_valid;
   logic                      busy;
   logic                      sel_err;
   logic [3:0]                drop_cnt;

   int total;
   int bad;
   int exp_drop;
   logic [31:0] last_data;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   wb_select_unit #(
      .DATA_W    (DATA_W),
      .NUM_SRC   (NUM_SRC),
      .SEL_W     (SEL_W),
      .CONST_SEL (7),
      .CONST_VAL (32'h0000_00E3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .src_data (src_data),
      .sel      (sel),
      .wb_req   (wb_req),
      .wb_ready (wb_ready),
      .wb_data  (wb_data),
      .wb_valid (wb_valid),
      .busy     (busy),
      .sel_err  (sel_err),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: record every value accepted by the register file
   always @(posedge clk) begin
      if (reset && wb_valid && wb_ready) obs_q.push_back(wb_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] expmap(input int s);
      if (s < 7) return 32'h1000_0000 + s;
      if (s == 7) return 32'h0000_00E3;
      return 32'h1000_0000 + s - 1;
   endfunction

   task automatic set_src(input logic [31:0] xr);
      for (int k = 0; k < NUM_SRC; k++)
         src_data[k*DATA_W +: DATA_W] = (32'h1000_0000 + k) ^ xr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; wb_req = 1'b1; wb_ready = 1'b1; sel = 4'd3;
      set_src(32'h0);
      tick(); tick();
      total++;
      if (wb_data !== 32'h0 || wb_valid !== 1'b0 || busy !== 1'b0 ||
          sel_err !== 1'b0 || drop_cnt !== 4'd0) begin
         bad++;
         $display("FAIL reset_state: data=%h valid=%b busy=%b err=%b drop=%0d required all zero",
                  wb_data, wb_valid, busy, sel_err, drop_cnt);
      end
      // first edge with reset high must already capture
      wb_ready = 1'b0; sel = 4'd1; reset = 1'b1;
      exp_q.push_back(expmap(1));
      tick();
      wb_req = 1'b0;
      total++;
      if (wb_valid !== 1'b1 || wb_data !== expmap(1)) begin
         bad++;
         $display("FAIL first_capture: valid=%b data=%h required valid=1 data=%h",
                  wb_valid, wb_data, expmap(1));
      end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      last_data = expmap(1);
   endtask

   task automatic test_mapping();
      int codes[5] = '{3, 7, 8, 0, 6};
      foreach (codes[i]) begin
         sel = SEL_W'(codes[i]); wb_req = 1'b1;
         exp_q.push_back(expmap(codes[i]));
         tick();
         wb_req = 1'b0;
         total++;
         if (wb_valid !== 1'b1 || busy !== 1'b1 || wb_data !== expmap(codes[i])) begin
            bad++;
            $display("FAIL map_sel%0d: valid=%b busy=%b data=%h required 1 1 %h",
                     codes[i], wb_valid, busy, wb_data, expmap(codes[i]));
         end
         wb_ready = 1'b1;
         tick();
         wb_ready = 1'b0;
         total++;
         if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL valid_one_cycle_sel%0d: valid=%b busy=%b required 0 0",
                     codes[i], wb_valid, busy);
         end
         last_data = expmap(codes[i]);
      end
   endtask

   task automatic test_illegal();
      int codes[2] = '{9, 15};
      foreach (codes[i]) begin
         sel = SEL_W'(codes[i]); wb_req = 1'b1;
         tick();
         wb_req = 1'b0;
         total++;
         if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_data !== last_data || sel_err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_sel%0d: valid=%b busy=%b data=%h err=%b required 0 0 %h 1",
                     codes[i], wb_valid, busy, wb_data, sel_err, last_data);
         end
      end
      // ready while idle must do nothing
      wb_ready = 1'b1;
      tick(); tick();
      wb_ready = 1'b0;
      total++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_data !== last_data) begin
         bad++;
         $display("FAIL idle_ready: valid=%b busy=%b data=%h required 0 0 %h",
                  wb_valid, busy, wb_data, last_data);
      end
      // sticky error survives a legal transfer
      sel = 4'd5; wb_req = 1'b1;
      exp_q.push_back(expmap(5));
      tick();
      wb_req = 1'b0; wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      last_data = expmap(5);
      total++;
      if (sel_err !== 1'b1 || wb_data !== expmap(5)) begin
         bad++;
         $display("FAIL err_sticky: err=%b data=%h required 1 %h", sel_err, wb_data, expmap(5));
      end
   endtask

   task automatic test_back_to_back();
      sel = 4'd4; wb_req = 1'b1;
      exp_q.push_back(expmap(4));
      tick();
      // ready and a new request together: complete, drop the request
      sel = 4'd1; wb_ready = 1'b1;
      tick();
      exp_drop++;
      wb_req = 1'b0; wb_ready = 1'b0;
      total++;
      if (busy !== 1'b0 || wb_valid !== 1'b0 || drop_cnt !== 4'(exp_drop)) begin
         bad++;
         $display("FAIL ready_and_req: busy=%b valid=%b drop=%0d required 0 0 %0d",
                  busy, wb_valid, drop_cnt, exp_drop);
      end
      tick();
      total++;
      if (busy !== 1'b0 || wb_data !== expmap(4)) begin
         bad++;
         $display("FAIL dropped_not_captured: busy=%b data=%h required 0 %h",
                  busy, wb_data, expmap(4));
      end
      // immediate new capture after returning to idle
      sel = 4'd6; wb_req = 1'b1;
      exp_q.push_back(expmap(6));
      tick();
      wb_req = 1'b0;
      total++;
      if (wb_valid !== 1'b1 || wb_data !== expmap(6)) begin
         bad++;
         $display("FAIL b2b_capture: valid=%b data=%h required 1 %h", wb_valid, wb_data, expmap(6));
      end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      last_data = expmap(6);
   endtask

   task automatic test_hold();
      sel = 4'd2; wb_req = 1'b1;
      exp_q.push_back(expmap(2));
      tick();
      for (int i = 0; i < 20; i++) begin
         set_src($urandom());
         sel = SEL_W'($urandom_range(0, 15));
         tick();
         if (exp_drop < 15) exp_drop++;
         total++;
         if (wb_valid !== 1'b1 || wb_data !== 32'h1000_0002 || drop_cnt !== 4'(exp_drop)) begin
            bad++;
            $display("FAIL hold_cycle%0d: valid=%b data=%h drop=%0d required 1 10000002 %0d",
                     i, wb_valid, wb_data, drop_cnt, exp_drop);
         end
      end
      set_src(32'h0);
      wb_req = 1'b0; wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      last_data = expmap(2);
      total++;
      if (wb_valid !== 1'b0 || drop_cnt !== 4'd15) begin
         bad++;
         $display("FAIL drop_saturate: valid=%b drop=%0d required 0 15", wb_valid, drop_cnt);
      end
   endtask

   task automatic test_reset_in_hold();
      sel = 4'd5; wb_req = 1'b1;
      tick();
      wb_req = 1'b0;
      // reset wins even with ready asserted: nothing is delivered
      reset = 1'b0; wb_ready = 1'b1;
      tick();
      reset = 1'b1; wb_ready = 1'b0;
      exp_drop = 0;
      last_data = 32'h0;
      total++;
      if (wb_data !== 32'h0 || wb_valid !== 1'b0 || busy !== 1'b0 ||
          sel_err !== 1'b0 || drop_cnt !== 4'd0) begin
         bad++;
         $display("FAIL reset_in_hold: data=%h valid=%b busy=%b err=%b drop=%0d required all zero",
                  wb_data, wb_valid, busy, sel_err, drop_cnt);
      end
      tick();
      total++;
      if (wb_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL after_reset_idle: valid=%b busy=%b required 0 0", wb_valid, busy);
      end
   endtask

   task automatic test_drain();
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL sb_count: observed=%0d transfers required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [31:0] o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_data: observed=%h required %h", o, e);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0; exp_drop = 0; last_data = '0;
      reset = 1'b0; wb_req = 1'b0; wb_ready = 1'b0; sel = '0; src_data = '0;
      test_reset();
      test_mapping();
      test_illegal();
      test_back_to_back();
      test_hold();
      test_reset_in_hold();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
